// File: rtl/ctrl_req_arbiter.sv
// Round-robin arbiter and sequencer in front of the cache controller operation port.
// The controller operation type lives in this file so that the block compiles on its own.

package ctrl_types_pkg;
  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;
endpackage

module ctrl_req_arbiter
  import ctrl_types_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  operation_e                 req_op [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic                       resp_succ,
  output logic                       resp_timeout,
  output operation_e                 ctrl_operation_out,
  input  logic                       ctrl_rdy_in,
  input  logic                       ctrl_op_succ_in,
  output logic                       busy_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_out,
  output logic [CNT_W-1:0]           timeout_cnt_out
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  operation_e      op_q;
  logic [IdxW-1:0] g_q;
  logic [IdxW-1:0] last_grant_q;
  logic [TmrW-1:0] timer_q;
  logic            succ_q;
  logic            to_q;
  logic [CNT_W-1:0] tcnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IdxW-1:0]    gnt;

  // A request counts only when it carries a real operation.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = req_valid[i] && (req_op[i] != NOOP);
    end
  end

  // Round-robin search starting just after the last served requester; modulo skips
  // unused indices when NUM_REQ is not a power of two.
  always_comb begin
    found = 1'b0;
    gnt   = last_grant_q;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gnt   = IdxW'(idx);
      end
    end
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP, with timeout guard and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= NOOP;
      g_q          <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      timer_q      <= '0;
      succ_q       <= 1'b0;
      to_q         <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            op_q    <= req_op[gnt];
            g_q     <= gnt;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          // Controller ready is deliberately ignored while the operation is presented.
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          timer_q <= timer_q + 1'b1;
          if (ctrl_rdy_in) begin
            succ_q  <= ctrl_op_succ_in;
            to_q    <= 1'b0;
            state_q <= StResp;
          end else if (timer_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
            succ_q  <= 1'b0;
            to_q    <= 1'b1;
            if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          last_grant_q <= g_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and response outputs decoded from the registered state.
  always_comb begin
    req_ready    = '0;
    resp_valid   = '0;
    resp_succ    = 1'b0;
    resp_timeout = 1'b0;
    if (state_q == StIdle && found) req_ready[gnt] = 1'b1;
    if (state_q == StResp) begin
      resp_valid[g_q] = 1'b1;
      resp_succ       = succ_q;
      resp_timeout    = to_q;
    end
  end

  assign ctrl_operation_out = (state_q == StIssue) ? op_q : NOOP;
  assign busy_out           = (state_q != StIdle);
  assign grant_idx_out      = g_q;
  assign timeout_cnt_out    = tcnt_q;

endmodule

// File: tb/tb_ctrl_req_arbiter.sv
// Directed self-checking bench for ctrl_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8, CNT_W=8).

module tb_ctrl_req_arbiter;
  import ctrl_types_pkg::*;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  operation_e       req_op [4];
  logic [3:0]       req_ready;
  logic [3:0]       resp_valid;
  logic             resp_succ;
  logic             resp_timeout;
  operation_e       ctrl_operation_out;
  logic             ctrl_rdy_in;
  logic             ctrl_op_succ_in;
  logic             busy_out;
  logic [1:0]       grant_idx_out;
  logic [7:0]       timeout_cnt_out;

  int vectors;
  int miscompares;

  ctrl_req_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_op             (req_op),
    .req_ready          (req_ready),
    .resp_valid         (resp_valid),
    .resp_succ          (resp_succ),
    .resp_timeout       (resp_timeout),
    .ctrl_operation_out (ctrl_operation_out),
    .ctrl_rdy_in        (ctrl_rdy_in),
    .ctrl_op_succ_in    (ctrl_op_succ_in),
    .busy_out           (busy_out),
    .grant_idx_out      (grant_idx_out),
    .timeout_cnt_out    (timeout_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    for (int i = 0; i < 4; i++) req_op[i] = NOOP;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    ctrl_rdy_in = 1'b0;
    ctrl_op_succ_in = 1'b0;
    #2;
    vectors++;
    if (busy_out !== 1'b0 || req_ready !== 4'b0 || resp_valid !== 4'b0 ||
        ctrl_operation_out !== NOOP || timeout_cnt_out !== 8'd0 || grant_idx_out !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%b rdy=%b resp=%b op=%0d cnt=%0d gidx=%0d, want all 0/NOOP",
               busy_out, req_ready, resp_valid, ctrl_operation_out, timeout_cnt_out, grant_idx_out);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (busy_out !== 1'b0 || req_ready !== 4'b0 || resp_valid !== 4'b0 || resp_succ !== 1'b0 ||
          resp_timeout !== 1'b0 || ctrl_operation_out !== NOOP || timeout_cnt_out !== 8'd0 ||
          grant_idx_out !== 2'd0) begin
        miscompares++;
        $display("FAIL idle_after_reset c%0d: busy=%b rdy=%b resp=%b op=%0d, want 0/0/0/NOOP",
                 c, busy_out, req_ready, resp_valid, ctrl_operation_out);
      end
    end
  endtask

  task automatic test_single_op();
    tick();
    req_valid[2] = 1'b1;
    req_op[2]    = UPSERT;
    #1;
    vectors++;
    if (req_ready !== 4'b0100 || ctrl_operation_out !== NOOP) begin
      miscompares++;
      $display("FAIL single_accept: rdy=%b op=%0d, want 0100/NOOP", req_ready, ctrl_operation_out);
    end
    tick();  // ISSUE; requester drops its request, which must not matter
    clear_reqs();
    #1;
    vectors++;
    if (ctrl_operation_out !== UPSERT || busy_out !== 1'b1 || grant_idx_out !== 2'd2 ||
        req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL single_issue: op=%0d busy=%b gidx=%0d rdy=%b, want UPSERT/1/2/0000",
               ctrl_operation_out, busy_out, grant_idx_out, req_ready);
    end
    tick();
    tick();
    vectors++;
    if (ctrl_operation_out !== NOOP || resp_valid !== 4'b0) begin
      miscompares++;
      $display("FAIL single_wait: op=%0d resp=%b, want NOOP/0000", ctrl_operation_out, resp_valid);
    end
    tick();  // T+4
    ctrl_rdy_in = 1'b1;
    ctrl_op_succ_in = 1'b1;
    tick();  // T+5
    ctrl_rdy_in = 1'b0;
    ctrl_op_succ_in = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b0100 || resp_succ !== 1'b1 || resp_timeout !== 1'b0 ||
        grant_idx_out !== 2'd2) begin
      miscompares++;
      $display("FAIL single_resp: resp=%b succ=%b to=%b gidx=%0d, want 0100/1/0/2",
               resp_valid, resp_succ, resp_timeout, grant_idx_out);
    end
    tick();
    vectors++;
    if (resp_valid !== 4'b0 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: resp=%b busy=%b, want 0000/0", resp_valid, busy_out);
    end
  endtask

  task automatic test_noop_ignored();
    req_valid[1] = 1'b1;
    req_op[1]    = NOOP;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0 || busy_out !== 1'b0) begin
        miscompares++;
        $display("FAIL noop_ignored c%0d: rdy=%b busy=%b, want 0000/0", c, req_ready, busy_out);
      end
      tick();
    end
    clear_reqs();
  endtask

  task automatic test_rdy_at_timeout();
    req_valid[0] = 1'b1;
    req_op[0]    = DELETE;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL coinc_accept: rdy=%b, want 0001", req_ready);
    end
    tick();  // ISSUE
    clear_reqs();
    for (int c = 0; c < 8; c++) tick();  // last WAIT cycle, timer at 7
    ctrl_rdy_in = 1'b1;
    ctrl_op_succ_in = 1'b1;
    #1;
    vectors++;
    if (resp_valid !== 4'b0 || busy_out !== 1'b1) begin
      miscompares++;
      $display("FAIL coinc_wait: resp=%b busy=%b, want 0000/1", resp_valid, busy_out);
    end
    tick();
    ctrl_rdy_in = 1'b0;
    ctrl_op_succ_in = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b0001 || resp_succ !== 1'b1 || resp_timeout !== 1'b0 ||
        timeout_cnt_out !== 8'd0) begin
      miscompares++;
      $display("FAIL coinc_resp: resp=%b succ=%b to=%b cnt=%0d, want 0001/1/0/0",
               resp_valid, resp_succ, resp_timeout, timeout_cnt_out);
    end
    tick();
  endtask

  task automatic test_rdy_in_issue();
    req_valid[3] = 1'b1;
    req_op[3]    = READ;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL issue_rdy_accept: rdy=%b, want 1000", req_ready);
    end
    tick();  // ISSUE with a stray rdy
    clear_reqs();
    ctrl_rdy_in = 1'b1;
    ctrl_op_succ_in = 1'b1;
    tick();  // WAIT
    ctrl_rdy_in = 1'b0;
    ctrl_op_succ_in = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b0 || busy_out !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_rdy_ignored: resp=%b busy=%b, want 0000/1", resp_valid, busy_out);
    end
    tick();
    vectors++;
    if (resp_valid !== 4'b0) begin
      miscompares++;
      $display("FAIL issue_rdy_still_wait: resp=%b, want 0000", resp_valid);
    end
    ctrl_rdy_in = 1'b1;
    ctrl_op_succ_in = 1'b0;
    tick();
    ctrl_rdy_in = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b1000 || resp_succ !== 1'b0 || resp_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL issue_rdy_resp: resp=%b succ=%b to=%b, want 1000/0/0",
               resp_valid, resp_succ, resp_timeout);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_onehot [5];
    logic [1:0] exp_idx [5];
    exp_onehot[0] = 4'b0001; exp_idx[0] = 2'd0;
    exp_onehot[1] = 4'b0010; exp_idx[1] = 2'd1;
    exp_onehot[2] = 4'b1000; exp_idx[2] = 2'd3;
    exp_onehot[3] = 4'b0001; exp_idx[3] = 2'd0;
    exp_onehot[4] = 4'b0010; exp_idx[4] = 2'd1;
    req_valid = 4'b1011;
    req_op[0] = READ;
    req_op[1] = READ;
    req_op[3] = READ;
    for (int n = 0; n < 5; n++) begin
      #1;
      vectors++;
      if (req_ready !== exp_onehot[n]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: rdy=%b, want %b", n, req_ready, exp_onehot[n]);
      end
      tick();  // ISSUE
      vectors++;
      if (grant_idx_out !== exp_idx[n] || ctrl_operation_out !== READ) begin
        miscompares++;
        $display("FAIL rr_issue%0d: gidx=%0d op=%0d, want %0d/READ",
                 n, grant_idx_out, ctrl_operation_out, exp_idx[n]);
      end
      tick();
      tick();  // two cycles after ISSUE
      ctrl_rdy_in = 1'b1;
      ctrl_op_succ_in = 1'b1;
      tick();  // RESP
      ctrl_rdy_in = 1'b0;
      ctrl_op_succ_in = 1'b0;
      #1;
      vectors++;
      if (resp_valid !== exp_onehot[n] || resp_succ !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_resp%0d: resp=%b succ=%b, want %b/1",
                 n, resp_valid, resp_succ, exp_onehot[n]);
      end
      tick();  // back in IDLE; next grant must be immediate
    end
    clear_reqs();
    #1;
  endtask

  task automatic run_timeout_op();
    req_valid[1] = 1'b1;
    req_op[1]    = DELETE;
    tick();
    clear_reqs();
    for (int c = 0; c < 9; c++) tick();
    tick();
  endtask

  task automatic test_timeout();
    req_valid[1] = 1'b1;
    req_op[1]    = DELETE;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL to_accept: rdy=%b, want 0010", req_ready);
    end
    tick();  // ISSUE
    clear_reqs();
    for (int c = 0; c < 8; c++) tick();  // last WAIT cycle
    vectors++;
    if (resp_valid !== 4'b0 || timeout_cnt_out !== 8'd0) begin
      miscompares++;
      $display("FAIL to_early: resp=%b cnt=%0d, want 0000/0", resp_valid, timeout_cnt_out);
    end
    tick();  // RESP
    vectors++;
    if (resp_valid !== 4'b0010 || resp_succ !== 1'b0 || resp_timeout !== 1'b1 ||
        timeout_cnt_out !== 8'd1) begin
      miscompares++;
      $display("FAIL to_resp: resp=%b succ=%b to=%b cnt=%0d, want 0010/0/1/1",
               resp_valid, resp_succ, resp_timeout, timeout_cnt_out);
    end
    tick();
    for (int n = 2; n <= 260; n++) begin
      run_timeout_op();
      if (n == 254 || n == 255 || n == 260) begin
        vectors++;
        if (timeout_cnt_out !== ((n == 254) ? 8'd254 : 8'd255)) begin
          miscompares++;
          $display("FAIL to_count after %0d: cnt=%0d, want %0d",
                   n, timeout_cnt_out, (n == 254) ? 254 : 255);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen_resp;
    req_valid[2] = 1'b1;
    req_op[2]    = READ;
    tick();  // ISSUE
    clear_reqs();
    tick();
    tick();  // WAIT
    rst = 1'b1;
    #1;
    vectors++;
    if (busy_out !== 1'b0 || resp_valid !== 4'b0 || timeout_cnt_out !== 8'd0 ||
        grant_idx_out !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_values: busy=%b resp=%b cnt=%0d gidx=%0d, want 0/0000/0/0",
               busy_out, resp_valid, timeout_cnt_out, grant_idx_out);
    end
    tick();
    rst = 1'b0;
    seen_resp = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (resp_valid !== 4'b0) seen_resp = 1'b1;
    end
    vectors++;
    if (seen_resp) begin
      miscompares++;
      $display("FAIL midreset_no_resp: resp_valid seen=1, want 0");
    end
    req_valid[0] = 1'b1;
    req_op[0]    = READ;
    req_valid[3] = 1'b1;
    req_op[3]    = READ;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL midreset_priority: rdy=%b, want 0001", req_ready);
    end
    tick();  // ISSUE
    clear_reqs();
    tick();
    ctrl_rdy_in = 1'b1;
    ctrl_op_succ_in = 1'b1;
    tick();
    ctrl_rdy_in = 1'b0;
    ctrl_op_succ_in = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b0001 || resp_succ !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_resp: resp=%b succ=%b, want 0001/1", resp_valid, resp_succ);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_op();
    test_noop_ignored();
    test_rdy_at_timeout();
    test_rdy_in_issue();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
